// File: rtl/qed_commit_checker.sv
// QED commit checker: pairs original register writebacks with their shadow duplicates.
// Optional saturating match counter output is enabled by defining QED_CHECK_COUNT_EN.
module qed_commit_checker #(
  parameter int DEPTH      = 8,
  parameter int DATA_W     = 32,
  parameter int REG_OFFSET = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     wb_vld,
  input  logic [4:0]               wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     qed_consistent,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [4:0]               err_rd
`ifdef QED_CHECK_COUNT_EN
  ,
  output logic [15:0]              match_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [1:0] CODE_DATA  = 2'd1;
  localparam logic [1:0] CODE_ORDER = 2'd2;
  localparam logic [1:0] CODE_FLOW  = 2'd3;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [4:0]      err_rd_q, err_rd_d;

  logic   accept, is_orig, full, empty, rd_ok, push, match;
  entry_t head;

  assign head    = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign accept  = wb_vld & ena & (wb_rd != '0) & (state_q != ST_ERROR) & ~flush;
  assign is_orig = ({1'b0, wb_rd} < 6'(REG_OFFSET));
  // Widen to 6 bits so head.rd + REG_OFFSET cannot wrap into a false rd match.
  assign rd_ok   = ({1'b0, wb_rd} == ({1'b0, head.rd} + 6'(REG_OFFSET)));

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_rd_d   = err_rd_q;
    push       = 1'b0;
    match      = 1'b0;

    if (accept) begin
      if (is_orig) begin
        if (full) begin
          err_d      = 1'b1;
          err_code_d = CODE_FLOW;
        end else begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          state_d  = ST_CHECK;
        end
      end else if (empty) begin
        err_d      = 1'b1;
        err_code_d = CODE_FLOW;
      end else begin
        // The head is consumed whether or not the pair agrees.
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
        if (!rd_ok) begin
          err_d      = 1'b1;
          err_code_d = CODE_ORDER;
        end else if (wb_data != head.data) begin
          err_d      = 1'b1;
          err_code_d = CODE_DATA;
        end else begin
          match = 1'b1;
          if (count_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      if (err_d && !err_q) begin
        err_rd_d = wb_rd;
        state_d  = ST_ERROR;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      err_rd_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_rd_q   <= err_rd_d;
    end
  end

  // NOTE: storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: wb_rd, data: wb_data};
  end

`ifdef QED_CHECK_COUNT_EN
  logic [15:0] match_cnt_q;

  // Counts survive flush; only a full reset clears them.
  always_ff @(posedge clk) begin
    if (rst)                                   match_cnt_q <= 16'd0;
    else if (match && match_cnt_q != 16'hFFFF) match_cnt_q <= match_cnt_q + 16'd1;
  end

  assign match_cnt = match_cnt_q;
`endif

  assign occupancy      = count_q;
  assign err            = err_q;
  assign err_code       = err_code_q;
  assign err_rd         = err_rd_q;
  assign qed_consistent = empty & ~err_q;

endmodule

// File: doc/qed_commit_checker.md
Name: qed_commit_checker

Overview:
- Consumer side of the QED duplication flow. The instruction duplicator injects duplicate instructions that write shadow registers (rd+REG_OFFSET); this block watches the register-file writeback port and pairs each original write with its duplicate.
- Original writes are buffered in order. Each duplicate write is compared against the oldest buffered original.
- Raises a sticky error on any inconsistency and reports when the core is in a QED-consistent state (no pending originals).
- Sits beside the writeback stage; observes only, never stalls the core.

Parameters:
- DEPTH, 8, pending-original FIFO entries (power of 2, >=2)
- DATA_W, 32, writeback data width
- REG_OFFSET, 16, register index distance between original and duplicate

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ena  input  1  QED checking enable; when 0 writebacks are ignored
- wb_vld  input  1  register-file write this cycle
- wb_rd  input  5  destination register
- wb_data  input  DATA_W  written value
- flush  input  1  synchronous clear of FIFO and error state (not counters)
- qed_consistent  output  1  FIFO empty and no error
- occupancy  output  $clog2(DEPTH)+1  pending originals
- err  output  1  sticky error flag
- err_code  output  2  0 none, 1 data mismatch, 2 order/rd mismatch, 3 overflow/underflow
- err_rd  output  5  wb_rd of the offending write

Behaviour:
- Reset (and flush): FIFO empty, wr/rd pointers 0, occupancy 0, err 0, err_code 0, err_rd 0, qed_consistent 1, state IDLE.
- Accepted write = wb_vld & ena & wb_rd!=0 & state!=ERROR. All other writes are ignored.
- Classification: wb_rd in 1..REG_OFFSET-1 is ORIGINAL; wb_rd >= REG_OFFSET is DUPLICATE.
- ORIGINAL with FIFO not full: push {wb_rd, wb_data}; occupancy +1 on the next edge.
- ORIGINAL with FIFO full: no push; error code 3.
- DUPLICATE with FIFO empty: error code 3 (underflow).
- DUPLICATE with FIFO non-empty: pop the head and compare.
  - wb_rd != head.rd+REG_OFFSET: code 2. Takes priority over data.
  - Otherwise wb_data != head.data: code 1.
  - Otherwise match.
- The pop happens in every case, including on error.
- At most one write per cycle, so push and pop never coincide.
- Latency: err, err_code and err_rd are registered one cycle after the offending writeback edge. occupancy and qed_consistent update on the same edge as the push/pop.
- Pointers wrap modulo DEPTH. Occupancy saturates logic is not needed because full is checked.
- FSM:
  - IDLE: FIFO empty. Accepted original goes to CHECK; accepted duplicate goes to ERROR.
  - CHECK: FIFO non-empty. A matching pop that empties the FIFO goes to IDLE; any error goes to ERROR.
  - ERROR: sticky; only rst or flush leaves it, returning to IDLE.
- While in ERROR: FIFO frozen, err_code and err_rd hold the first error.
- flush and wb_vld in the same cycle: flush wins and the write is dropped.
- ena deasserted mid-sequence: FIFO contents are held. Checking resumes when ena returns.
- qed_consistent = (occupancy==0) & ~err, registered-equivalent (derived from state flops).

Optional Feature:
- Macro QED_CHECK_COUNT_EN.
- When defined, adds output match_cnt (16 bits), incremented on each successful comparison. It saturates at 16'hFFFF, resets to 0 on rst only, and is unaffected by flush.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Write r3=0x0000_00AA, then r19=0x0000_00AA -> after r3, occupancy 1 and qed_consistent 0; after r19, occupancy 0, qed_consistent 1, err 0 (match_cnt 1 with macro).
- Write r5=0x1234, then r21=0x1235 -> one cycle after the r21 write, err=1, err_code=1, err_rd=21. A subsequent r6 write is ignored; occupancy stays 0.
- Write r2=7, r4=9, then r20=9 -> err_code=2, err_rd=20 (order error; rd check beats data check).
- Write r16=0 with FIFO empty -> err_code=3, err_rd=16. Then assert flush -> err 0, qed_consistent 1.
- DEPTH=8: write r1..r8 as originals (r8 is original, 8<16); 9th original r9 -> err_code=3, err_rd=9, occupancy stays 8.
- Write r7=0x55 with ena=1; then with ena=0, write r23=0x00 (ignored); then with ena=1, write r23=0x55 -> no error, occupancy 0. Also: a write with wb_rd=0 never changes occupancy.
